// File: rtl/hdmi_island_scheduler_pkg.sv
// Shared definitions for the HDMI data-island scheduler: packet type codes,
// island phase lengths, source indices and the FSM state encoding.
package hdmi_packet_pkg;

    typedef enum logic [2:0] {
        PKT_NULL       = 3'd0,
        PKT_ACR        = 3'd1,
        PKT_AUDIO      = 3'd2,
        PKT_AVI        = 3'd3,
        PKT_AUDIO_INFO = 3'd4,
        PKT_SPD        = 3'd5
    } packetType_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PREAMBLE    = 3'd1,
        ST_LEAD_GUARD  = 3'd2,
        ST_PACKET      = 3'd3,
        ST_TRAIL_GUARD = 3'd4
    } islandState_t;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;

    // Pending-vector layout, highest priority at index 0.
    // Source index i is sent as packet type i+1.
    localparam int NUM_SOURCES    = 5;
    localparam int SRC_ACR        = 0;
    localparam int SRC_AUDIO      = 1;
    localparam int SRC_AVI        = 2;
    localparam int SRC_AUDIO_INFO = 3;
    localparam int SRC_SPD        = 4;

    // Number of distinct packet sources that currently have work.
    function automatic logic [2:0] countPending(input logic [NUM_SOURCES-1:0] pending);
        logic [2:0] total;
        total = 3'd0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            total = total + {2'b00, pending[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/hdmi_island_scheduler_if.sv
// Bundle between video timing / audio FIFO / infoframe control on one side
// and the island scheduler feeding the TMDS packet encoder on the other.
interface hdmi_island_if;

    logic        islandOpportunity;
    logic [11:0] blankCycles;
    logic        frameStart;
    logic        sampleFifoEmpty;
    logic [7:0]  samplesPerRegenPacket;
    logic [2:0]  infoframeEnable;

    logic        dataIslandPreamble;
    logic        dataIslandGuardBand;
    logic        packetStart;
    logic [2:0]  packetType;
    logic        sampleFifoReadEnable;
    logic        infoframeMissed;

    // Timing/control side that offers blanking and packet sources.
    modport master (
        output islandOpportunity, blankCycles, frameStart, sampleFifoEmpty,
               samplesPerRegenPacket, infoframeEnable,
        input  dataIslandPreamble, dataIslandGuardBand, packetStart, packetType,
               sampleFifoReadEnable, infoframeMissed
    );

    // Scheduler side.
    modport slave (
        input  islandOpportunity, blankCycles, frameStart, sampleFifoEmpty,
               samplesPerRegenPacket, infoframeEnable,
        output dataIslandPreamble, dataIslandGuardBand, packetStart, packetType,
               sampleFifoReadEnable, infoframeMissed
    );

endinterface

// File: rtl/hdmi_packet_arbiter.sv
// Combinational fixed-priority pick over the pending vector.
// Index 0 wins; an empty vector yields the NULL packet and no grant.
module hdmi_packet_arbiter
    import hdmi_packet_pkg::*;
(
    input  logic [NUM_SOURCES-1:0] pending,
    output packetType_t            pickType,
    output logic [NUM_SOURCES-1:0] grant
);

    // higherPending[i] is set when any source above index i has work
    logic [NUM_SOURCES-1:0] higherPending;

    assign higherPending[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_SOURCES; gi++) begin : gChain
            assign higherPending[gi] = higherPending[gi-1] | pending[gi-1];
        end
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : gGrant
            assign grant[gi] = pending[gi] & ~higherPending[gi];
        end
    endgenerate

    // Translate the one-hot grant into the packet type code
    always_comb begin
        pickType = PKT_NULL;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (grant[i]) begin
                pickType = packetType_t'(3'(i + 1));
            end
        end
    end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island scheduler. On each blanking opportunity it sizes an island
// from the available blanking and the number of pending packet sources, then
// walks preamble, leading guard, n packets and trailing guard, re-arbitrating
// at every packet boundary. Also keeps ACR cadence and per-frame infoframes.
module hdmi_island_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int MAX_PACKETS     = 18,
    parameter int ISLAND_OVERHEAD = 24
) (
    input  logic          clock,
    input  logic          resetN,
    hdmi_island_if.slave  bus
);

    // FSM and island counters
    islandState_t state;
    logic [4:0]   phaseCount;
    logic [4:0]   packetsLeft;

    // Registered outputs
    logic         preambleReg;
    logic         guardReg;
    logic         packetStartReg;
    packetType_t  packetTypeReg;
    logic         readEnableReg;
    logic         missedReg;

    // Pending sources and ACR cadence
    logic         acrPending;
    logic [2:0]   infoPending;
    logic [7:0]   acrCount;
    logic [7:0]   regenPrev;

    logic [NUM_SOURCES-1:0] pendingVec;
    logic [NUM_SOURCES-1:0] grant;
    logic [NUM_SOURCES-1:0] grantVec;
    packetType_t            pickType;

    // AUDIO is pending whenever the sample FIFO holds data.
    assign pendingVec = {infoPending, ~bus.sampleFifoEmpty, acrPending};

    hdmi_packet_arbiter uArbiter (
        .pending  (pendingVec),
        .pickType (pickType),
        .grant    (grant)
    );

    // Island sizing: packets that fit after fixed overhead, capped by the
    // HDMI limit and by how many sources actually have something to send.
    logic [6:0] slotsFit;
    logic [4:0] nMax;
    logic [2:0] pendingCount;
    logic [4:0] islandPackets;
    logic       islandFits;
    logic       islandGo;

    assign slotsFit      = 7'((bus.blankCycles - 12'(ISLAND_OVERHEAD)) >> 5);
    assign nMax          = (slotsFit > 7'(MAX_PACKETS)) ? 5'(MAX_PACKETS) : slotsFit[4:0];
    assign pendingCount  = countPending(pendingVec);
    assign islandPackets = ({2'b00, pendingCount} < nMax) ? {2'b00, pendingCount} : nMax;
    assign islandFits    = bus.blankCycles >= 12'(ISLAND_OVERHEAD + PACKET_LEN);
    assign islandGo      = bus.islandOpportunity && islandFits && (islandPackets != 5'd0);

    // A new packet begins on the edge that ends the leading guard or ends a
    // packet that is not the last one of the island.
    logic slotBoundary;
    assign slotBoundary = (phaseCount == 5'd0) &&
                          ((state == ST_LEAD_GUARD) ||
                           ((state == ST_PACKET) && (packetsLeft != 5'd1)));
    assign grantVec = grant & {NUM_SOURCES{slotBoundary}};

    // ACR cadence: count AUDIO packets, wrap and request ACR at the programmed ratio
    logic regenEnabled;
    logic regenChanged;
    logic acrWrap;

    assign regenEnabled = bus.samplesPerRegenPacket != 8'd0;
    assign regenChanged = bus.samplesPerRegenPacket != regenPrev;
    assign acrWrap      = grantVec[SRC_AUDIO] && regenEnabled && !regenChanged &&
                          (acrCount == bus.samplesPerRegenPacket - 8'd1);

    // Infoframe bits cleared by this cycle's grant; a frameStart re-arm wins.
    logic [2:0] infoClear;
    logic [2:0] infoKept;

    assign infoClear = grantVec[SRC_SPD:SRC_AVI];
    assign infoKept  = infoPending & ~infoClear;

    // Island sequencer with registered strobes and packet type
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state          <= ST_IDLE;
            phaseCount     <= 5'd0;
            packetsLeft    <= 5'd0;
            preambleReg    <= 1'b0;
            guardReg       <= 1'b0;
            packetStartReg <= 1'b0;
            packetTypeReg  <= PKT_NULL;
            readEnableReg  <= 1'b0;
        end else begin
            packetStartReg <= 1'b0;
            readEnableReg  <= 1'b0;
            if (slotBoundary) begin
                packetStartReg <= 1'b1;
                packetTypeReg  <= pickType;
                readEnableReg  <= grant[SRC_AUDIO];
            end
            case (state)
                ST_IDLE: begin
                    if (islandGo) begin
                        state       <= ST_PREAMBLE;
                        phaseCount  <= 5'(PREAMBLE_LEN - 1);
                        packetsLeft <= islandPackets;
                        preambleReg <= 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    if (phaseCount == 5'd0) begin
                        state       <= ST_LEAD_GUARD;
                        phaseCount  <= 5'(GUARD_LEN - 1);
                        preambleReg <= 1'b0;
                        guardReg    <= 1'b1;
                    end else begin
                        phaseCount <= phaseCount - 5'd1;
                    end
                end
                ST_LEAD_GUARD: begin
                    if (phaseCount == 5'd0) begin
                        state      <= ST_PACKET;
                        phaseCount <= 5'(PACKET_LEN - 1);
                        guardReg   <= 1'b0;
                    end else begin
                        phaseCount <= phaseCount - 5'd1;
                    end
                end
                ST_PACKET: begin
                    if (phaseCount == 5'd0) begin
                        if (packetsLeft == 5'd1) begin
                            state         <= ST_TRAIL_GUARD;
                            phaseCount    <= 5'(GUARD_LEN - 1);
                            guardReg      <= 1'b1;
                            packetTypeReg <= PKT_NULL;
                        end else begin
                            packetsLeft <= packetsLeft - 5'd1;
                            phaseCount  <= 5'(PACKET_LEN - 1);
                        end
                    end else begin
                        phaseCount <= phaseCount - 5'd1;
                    end
                end
                ST_TRAIL_GUARD: begin
                    if (phaseCount == 5'd0) begin
                        state    <= ST_IDLE;
                        guardReg <= 1'b0;
                    end else begin
                        phaseCount <= phaseCount - 5'd1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    preambleReg <= 1'b0;
                    guardReg    <= 1'b0;
                end
            endcase
        end
    end

    // ACR counter and ACR request flag
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            acrCount   <= 8'd0;
            regenPrev  <= 8'd0;
            acrPending <= 1'b0;
        end else begin
            regenPrev <= bus.samplesPerRegenPacket;
            if (regenChanged) begin
                acrCount <= 8'd0;
            end else if (grantVec[SRC_AUDIO] && regenEnabled) begin
                acrCount <= acrWrap ? 8'd0 : acrCount + 8'd1;
            end
            acrPending <= acrWrap | (acrPending & ~grantVec[SRC_ACR]);
        end
    end

    // Per-frame infoframe arming and sticky missed flag
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            infoPending <= 3'b000;
            missedReg   <= 1'b0;
        end else begin
            if (bus.frameStart) begin
                infoPending <= infoKept | bus.infoframeEnable;
                if (|(infoKept & bus.infoframeEnable)) begin
                    missedReg <= 1'b1;
                end
            end else begin
                infoPending <= infoKept;
            end
        end
    end

    assign bus.dataIslandPreamble   = preambleReg;
    assign bus.dataIslandGuardBand  = guardReg;
    assign bus.packetStart          = packetStartReg;
    assign bus.packetType           = packetTypeReg;
    assign bus.sampleFifoReadEnable = readEnableReg;
    assign bus.infoframeMissed      = missedReg;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for hdmi_island_scheduler: walks islands cycle by cycle and
// checks phase lengths, packet order/timing, FIFO pops, ACR cadence,
// infoframe bookkeeping and asynchronous reset.
module tb_hdmi_island_scheduler;

    logic clock;
    logic resetN;

    hdmi_island_if bus ();

    hdmi_island_scheduler #(
        .MAX_PACKETS     (18),
        .ISLAND_OVERHEAD (24)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent capture window
    int startCyc [32];
    int startTyp [32];
    int nStarts;
    int nPops;
    int popCyc;
    int preCount;
    int firstPre;
    int guardCount;
    int lastGuard;
    int overlap;
    bit drainOnPop;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseFrameStart();
        bus.frameStart = 1'b1;
        step();
        bus.frameStart = 1'b0;
    endtask

    // Cycle t = the cycle islandOpportunity is high; returns observing t+1.
    task automatic openIsland(input int blank);
        bus.blankCycles       = 12'(blank);
        bus.islandOpportunity = 1'b1;
        step();
        bus.islandOpportunity = 1'b0;
    endtask

    // Observe cycles t+1 .. t+cycles, recording strobes relative to t.
    task automatic captureIsland(input int cycles);
        nStarts = 0; nPops = 0; popCyc = -1; preCount = 0; firstPre = -1;
        guardCount = 0; lastGuard = -1; overlap = 0;
        for (int c = 1; c <= cycles; c++) begin
            if (bus.dataIslandPreamble) begin
                preCount++;
                if (firstPre < 0) firstPre = c;
            end
            if (bus.dataIslandGuardBand) begin
                guardCount++;
                lastGuard = c;
            end
            if (bus.dataIslandPreamble && bus.dataIslandGuardBand) overlap++;
            if (bus.packetStart && nStarts < 32) begin
                startCyc[nStarts] = c;
                startTyp[nStarts] = int'(bus.packetType);
                nStarts++;
            end
            if (bus.sampleFifoReadEnable) begin
                nPops++;
                popCyc = c;
                if (drainOnPop) bus.sampleFifoEmpty = 1'b1;
            end
            step();
        end
        $display("island: preamble=%0d guard=%0d packets=%0d pops=%0d",
                 preCount, guardCount, nStarts, nPops);
    endtask

    initial begin
        resetN                    = 1'b0;
        bus.islandOpportunity     = 1'b0;
        bus.blankCycles           = 12'd0;
        bus.frameStart            = 1'b0;
        bus.sampleFifoEmpty       = 1'b1;
        bus.samplesPerRegenPacket = 8'd0;
        bus.infoframeEnable       = 3'b000;
        drainOnPop                = 1'b0;

        repeat (2) step();
        check("reset_preamble", int'(bus.dataIslandPreamble), 0);
        check("reset_guard", int'(bus.dataIslandGuardBand), 0);
        check("reset_packetStart", int'(bus.packetStart), 0);
        check("reset_packetType", int'(bus.packetType), 0);
        check("reset_readEnable", int'(bus.sampleFifoReadEnable), 0);
        check("reset_missed", int'(bus.infoframeMissed), 0);
        resetN = 1'b1;
        step();

        // 1: single audio packet island
        bus.sampleFifoEmpty = 1'b0;
        openIsland(370);
        captureIsland(47);
        check("t1_firstPreamble", firstPre, 1);
        check("t1_preambleLen", preCount, 8);
        check("t1_guardLen", guardCount, 4);
        check("t1_overlap", overlap, 0);
        check("t1_packets", nStarts, 1);
        check("t1_startCycle", startCyc[0], 11);
        check("t1_type", startTyp[0], 2);
        check("t1_pops", nPops, 1);
        check("t1_popCycle", popCyc, 11);
        check("t1_trailGuard", lastGuard, 44);

        // 2: audio plus three infoframes, FIFO drains on first pop
        bus.infoframeEnable = 3'b111;
        pulseFrameStart();
        bus.infoframeEnable = 3'b000;
        drainOnPop = 1'b1;
        openIsland(370);
        captureIsland(13 + 128 + 2);
        drainOnPop = 1'b0;
        check("t2_packets", nStarts, 4);
        check("t2_type0", startTyp[0], 2);
        check("t2_type1", startTyp[1], 3);
        check("t2_type2", startTyp[2], 4);
        check("t2_type3", startTyp[3], 5);
        check("t2_start3", startCyc[3], 107);
        check("t2_pops", nPops, 1);
        check("t2_trailGuard", lastGuard, 140);
        check("t2_missed", int'(bus.infoframeMissed), 0);

        // 3: ACR after every 4th audio packet, ahead of audio
        bus.sampleFifoEmpty       = 1'b0;
        bus.samplesPerRegenPacket = 8'd4;
        repeat (2) step();
        for (int k = 0; k < 4; k++) begin
            openIsland(370);
            captureIsland(47);
            check("t3_audioOnlyPackets", nStarts, 1);
            check("t3_audioOnlyType", startTyp[0], 2);
        end
        openIsland(370);
        captureIsland(13 + 64 + 2);
        check("t3_acrPackets", nStarts, 2);
        check("t3_acrFirst", startTyp[0], 1);
        check("t3_audioSecond", startTyp[1], 2);
        check("t3_acrPopCycle", popCyc, 43);
        check("t3_acrTrailGuard", lastGuard, 76);

        // 4: blanking boundary
        openIsland(55);
        captureIsland(15);
        check("t4_short_preamble", preCount, 0);
        check("t4_short_packets", nStarts, 0);
        openIsland(56);
        captureIsland(47);
        check("t4_min_packets", nStarts, 1);
        check("t4_min_type", startTyp[0], 2);
        check("t4_min_trailGuard", lastGuard, 44);

        // 5: audio counted at sizing but FIFO empties before its slot
        bus.infoframeEnable = 3'b011;
        pulseFrameStart();
        bus.infoframeEnable = 3'b000;
        openIsland(370);
        bus.sampleFifoEmpty = 1'b1;
        captureIsland(13 + 96 + 2);
        check("t5_packets", nStarts, 3);
        check("t5_type0", startTyp[0], 3);
        check("t5_type1", startTyp[1], 4);
        check("t5_type2_null", startTyp[2], 0);
        check("t5_start2", startCyc[2], 75);
        check("t5_pops", nPops, 0);
        check("t5_trailGuard", lastGuard, 108);

        // 6: SPD never fits, missed flag is sticky
        bus.infoframeEnable = 3'b100;
        pulseFrameStart();
        check("t6_missed_first", int'(bus.infoframeMissed), 0);
        openIsland(40);
        captureIsland(15);
        check("t6_short_preamble", preCount, 0);
        pulseFrameStart();
        check("t6_missed_set", int'(bus.infoframeMissed), 1);
        bus.infoframeEnable = 3'b000;
        pulseFrameStart();
        repeat (3) step();
        check("t6_missed_sticky", int'(bus.infoframeMissed), 1);

        // Reset in the middle of a packet
        bus.sampleFifoEmpty = 1'b0;
        openIsland(56);
        repeat (19) step();
        check("t6_midPacketType", int'(bus.packetType), 2);
        #2;
        resetN = 1'b0;
        #1;
        check("t6_rst_preamble", int'(bus.dataIslandPreamble), 0);
        check("t6_rst_guard", int'(bus.dataIslandGuardBand), 0);
        check("t6_rst_packetStart", int'(bus.packetStart), 0);
        check("t6_rst_packetType", int'(bus.packetType), 0);
        check("t6_rst_readEnable", int'(bus.sampleFifoReadEnable), 0);
        check("t6_rst_missed", int'(bus.infoframeMissed), 0);
        #1;
        resetN = 1'b1;
        step();
        captureIsland(40);
        check("t6_postReset_idle", preCount + guardCount + nStarts, 0);
        openIsland(370);
        captureIsland(47);
        check("t6_postReset_packets", nStarts, 1);
        check("t6_postReset_start", startCyc[0], 11);
        check("t6_postReset_type", startTyp[0], 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
